// File: rtl/mont_conversion.sv
// Montgomery-form conversion x*2**WIDTH mod N by WIDTH serial modular doublings; optional MONT_INPUT_CHECK_EN rejects x_in>=N or N==0.
// Latency WIDTH+1 cycles from accept to the valid_out pulse; no output backpressure, valid_in is ignored while busy_out is high.
module mont_conversion #(
    parameter int WIDTH = 512
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] N,
    input  logic             valid_in,
    output logic [WIDTH-1:0] x_mont_out,
    output logic             valid_out,
    output logic             busy_out
`ifdef MONT_INPUT_CHECK_EN
    ,
    output logic             error_out
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0] n_reg, n_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic [WIDTH-1:0] x_mont_nxt;
    logic             valid_nxt;
    logic             busy_nxt;
    logic             req_bad;

    // 2*acc can reach 2N-2, which needs the extra bit when N's MSB is set
    logic [WIDTH:0]   t;
    logic             t_ge;
    logic [WIDTH-1:0] acc_dbl;

    assign t       = {acc, 1'b0};
    assign t_ge    = (t >= {1'b0, n_reg});
    assign acc_dbl = t_ge ? WIDTH'(t - {1'b0, n_reg}) : t[WIDTH-1:0];

`ifdef MONT_INPUT_CHECK_EN
    logic error_nxt;
    assign req_bad = (x_in >= N) || (N == '0);
`else
    assign req_bad = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        n_nxt      = n_reg;
        count_nxt  = count;
        x_mont_nxt = x_mont_out;
        valid_nxt  = valid_out;
        busy_nxt   = busy_out;
`ifdef MONT_INPUT_CHECK_EN
        error_nxt  = 1'b0;
`endif
        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
`ifdef MONT_INPUT_CHECK_EN
                error_nxt = valid_in && req_bad;
`endif
                if (valid_in && !req_bad) begin
                    acc_nxt   = x_in;
                    n_nxt     = N;
                    count_nxt = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                acc_nxt   = acc_dbl;
                count_nxt = count + CW'(1);
                if (count == CW'(WIDTH - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                x_mont_nxt = acc;
                valid_nxt  = 1'b1;
                busy_nxt   = 1'b0;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            acc        <= '0;
            n_reg      <= '0;
            count      <= '0;
            x_mont_out <= '0;
            valid_out  <= 1'b0;
            busy_out   <= 1'b0;
`ifdef MONT_INPUT_CHECK_EN
            error_out  <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            n_reg      <= n_nxt;
            count      <= count_nxt;
            x_mont_out <= x_mont_nxt;
            valid_out  <= valid_nxt;
            busy_out   <= busy_nxt;
`ifdef MONT_INPUT_CHECK_EN
            error_out  <= error_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mont_conversion.sv
// Bench for mont_conversion at WIDTH=8: directed cases, back-to-back, reset abort and random round trips.
// Reference is plain modular arithmetic plus a behavioural Montgomery reduction; rejection cases exist only with MONT_INPUT_CHECK_EN.
module tb_mont_conversion;

    localparam int W = 8;

    logic         clk_in   = 1'b0;
    logic         rst_in   = 1'b1;
    logic [W-1:0] x_in     = '0;
    logic [W-1:0] n_in     = '0;
    logic         valid_in = 1'b0;
    logic [W-1:0] x_mont_out;
    logic         valid_out;
    logic         busy_out;
`ifdef MONT_INPUT_CHECK_EN
    logic         error_out;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk_in = ~clk_in;

    mont_conversion #(.WIDTH(W)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .x_in       (x_in),
        .N          (n_in),
        .valid_in   (valid_in),
        .x_mont_out (x_mont_out),
        .valid_out  (valid_out),
        .busy_out   (busy_out)
`ifdef MONT_INPUT_CHECK_EN
        ,
        .error_out  (error_out)
`endif
    );

    function automatic int mont_model(input int x, input int n);
        return (x * 256) % n;
    endfunction

    // REDC with R=256 and n' = -n^-1 mod 256, found by search
    function automatic int redc(input int t, input int n);
        int np;
        int m;
        int u;
        np = 0;
        for (int k = 0; k < 256; k++) begin
            if (((n * k) + 1) % 256 == 0) np = k;
        end
        m = ((t % 256) * np) % 256;
        u = (t + m * n) / 256;
        if (u >= n) u = u - n;
        return u;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_result(input string tag, output logic [W-1:0] res, output int lat);
        lat = 0;
        while (valid_out !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_valid_seen"}, {31'd0, valid_out}, 32'd1);
        res = x_mont_out;
    endtask

    task automatic convert(input string tag, input int x, input int n,
                           output logic [W-1:0] res, output int lat);
        x_in     = W'(x);
        n_in     = W'(n);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        wait_result(tag, res, lat);
    endtask

    int dir_x [4] = '{250, 12, 0, 0};
    int dir_n [4] = '{251, 13, 13, 1};

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] res;
        int           lat;
        int           gap;
        int           seen;
        int           n;
        int           x;

        rst_in = 1'b1;
        tick();
        tick();
        check("rst_x_mont", {24'd0, x_mont_out}, 32'd0);
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_busy", {31'd0, busy_out}, 32'd0);
`ifdef MONT_INPUT_CHECK_EN
        check("rst_error", {31'd0, error_out}, 32'd0);
`endif
        rst_in = 1'b0;
        tick();

        // Single request with cycle-exact latency and busy window
        x_in     = 8'd5;
        n_in     = 8'd13;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        check("t1_busy_e0", {31'd0, busy_out}, 32'd1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("t1_busy_e%0d", k), {31'd0, busy_out}, 32'd1);
            check($sformatf("t1_novalid_e%0d", k), {31'd0, valid_out}, 32'd0);
        end
        tick();
        check("t1_valid_e9", {31'd0, valid_out}, 32'd1);
        check("t1_result", {24'd0, x_mont_out}, 32'(mont_model(5, 13)));
        check("t1_busy_e9", {31'd0, busy_out}, 32'd0);
        tick();
        check("t1_pulse_end", {31'd0, valid_out}, 32'd0);
        check("t1_hold", {24'd0, x_mont_out}, 32'(mont_model(5, 13)));

        // Directed boundary cases
        for (int i = 0; i < 4; i++) begin
            convert($sformatf("dir%0d", i), dir_x[i], dir_n[i], res, lat);
            check($sformatf("dir%0d_result", i), {24'd0, res}, 32'(mont_model(dir_x[i], dir_n[i])));
            check($sformatf("dir%0d_latency", i), 32'(lat), 32'd9);
        end
        check("dir_n251_literal", 32'(mont_model(250, 251)), 32'd246);

        // Back-to-back with ignored pulses while busy
        convert("b2b_first", 5, 13, res, lat);
        check("b2b_first_result", {24'd0, res}, 32'd6);
        x_in     = 8'd12;
        n_in     = 8'd13;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            x_in     = 8'd3;
            n_in     = 8'd7;
            valid_in = 1'b1;
            tick();
            valid_in = 1'b0;
        end
        wait_result("b2b_second", res, lat);
        gap = 1 + 6 + lat;
        check("b2b_second_result", {24'd0, res}, 32'd4);
        check("b2b_spacing", 32'(gap), 32'd10);
        tick();
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (valid_out === 1'b1) seen = 1;
        end
        check("b2b_no_extra_result", 32'(seen), 32'd0);

        // Reset mid-operation
        x_in     = 8'd5;
        n_in     = 8'd13;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        repeat (4) tick();
        rst_in = 1'b1;
        tick();
        check("rstmid_x_mont", {24'd0, x_mont_out}, 32'd0);
        check("rstmid_valid", {31'd0, valid_out}, 32'd0);
        check("rstmid_busy", {31'd0, busy_out}, 32'd0);
        rst_in = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (valid_out === 1'b1) seen = 1;
        end
        check("rstmid_no_valid", 32'(seen), 32'd0);
        convert("rstmid_fresh", 5, 13, res, lat);
        check("rstmid_fresh_result", {24'd0, res}, 32'd6);

        // Round trip through Montgomery reduction
        convert("rt_fixed", 7, 13, res, lat);
        check("rt_fixed_conv", {24'd0, res}, 32'd11);
        check("rt_fixed_back", 32'(redc(int'(res), 13)), 32'd7);
        for (int i = 0; i < 200; i++) begin
            n = int'($urandom_range(127, 0)) * 2 + 1;
            x = int'($urandom_range(n - 1, 0));
            convert("rt_rand", x, n, res, lat);
            check($sformatf("rt_conv x=%0d n=%0d", x, n), {24'd0, res}, 32'(mont_model(x, n)));
            check($sformatf("rt_back x=%0d n=%0d", x, n), 32'(redc(int'(res), n)), 32'(x));
        end

`ifdef MONT_INPUT_CHECK_EN
        // Rejected requests leave the previous result untouched
        x = int'(x_mont_out);
        x_in     = 8'd13;
        n_in     = 8'd13;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        check("err_x_ge_n", {31'd0, error_out}, 32'd1);
        check("err_x_ge_n_busy", {31'd0, busy_out}, 32'd0);
        tick();
        check("err_x_ge_n_clear", {31'd0, error_out}, 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (valid_out === 1'b1 || busy_out === 1'b1) seen = 1;
        end
        check("err_x_ge_n_idle", 32'(seen), 32'd0);
        check("err_x_ge_n_hold", {24'd0, x_mont_out}, 32'(x));
        x_in     = 8'd0;
        n_in     = 8'd0;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        check("err_n_zero", {31'd0, error_out}, 32'd1);
        tick();
        check("err_n_zero_clear", {31'd0, error_out}, 32'd0);
        x_in     = 8'd12;
        n_in     = 8'd13;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        check("err_ok_no_error", {31'd0, error_out}, 32'd0);
        wait_result("err_ok", res, lat);
        check("err_ok_result", {24'd0, res}, 32'd4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
